// File: rtl/v_frac_pkg.sv
// Shared types for the redundant-fraction shift-right reader: FSM encoding, rail pair, carry width.
package v_frac_pkg;

  localparam int RAIL_CARRY_W      = 2;
  localparam int UNROLLING_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // Plus/minus word pair at the default datapath width.
  typedef struct packed {
    logic [UNROLLING_DEFAULT-1:0] plus;
    logic [UNROLLING_DEFAULT-1:0] minus;
  } rail_pair_t;

endpackage

// File: rtl/v_frac_word_ram.sv
// Dual-rail 1W1R word memory; registered write and registered read (1-cycle read latency).
module v_frac_word_ram #(
  parameter int ADDR_WIDTH = 7,
  parameter int WIDTH      = 64
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_plus,
  input  logic [WIDTH-1:0]      wr_minus,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_plus,
  output logic [WIDTH-1:0]      rd_minus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [2*WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= {wr_plus, wr_minus};
    end
    if (rd_en) begin
      {rd_plus, rd_minus} <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/v_frac_bits_shr_reader.sv
// Streams a stored redundant fraction MSW-first shifted right by one; 2 cycles start-to-valid, one word per
// 2 cycles, holds the word while out_ready=0. Optional zero_flag output under V_SHR_ZERO_FLAG_EN.
module v_frac_bits_shr_reader
  import v_frac_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int UNROLLING  = 64
) (
  input  logic                    clk,
  input  logic                    syn_reset_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [UNROLLING-1:0]    wr_plus_frac,
  input  logic [UNROLLING-1:0]    wr_minus_frac,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   last_addr,
  input  logic [RAIL_CARRY_W-1:0] shift_in,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic [UNROLLING-1:0]    w_plus_frac,
  output logic [UNROLLING-1:0]    w_minus_frac,
  output logic [RAIL_CARRY_W-1:0] shift_out,
`ifdef V_SHR_ZERO_FLAG_EN
  output logic                    zero_flag,
`endif
  output logic                    done
);

  state_e                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [RAIL_CARRY_W-1:0] carry;
  logic [UNROLLING-1:0]    rd_plus;
  logic [UNROLLING-1:0]    rd_minus;
  logic [RAIL_CARRY_W-1:0] lsb_pair;
  logic                    accept;

  v_frac_word_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (UNROLLING)
  ) u_ram (
    .clk      (clk),
    .wr_en    (wr_en && (state == ST_IDLE)),
    .wr_addr  (wr_addr),
    .wr_plus  (wr_plus_frac),
    .wr_minus (wr_minus_frac),
    .rd_en    (state == ST_FETCH),
    .rd_addr  (addr),
    .rd_plus  (rd_plus),
    .rd_minus (rd_minus)
  );

  // Read data and carry are both registers and frozen during EMIT, so the word is stable under stall.
  assign out_valid    = (state == ST_EMIT);
  assign busy         = (state == ST_FETCH) || (state == ST_EMIT);
  assign done         = (state == ST_FIN);
  assign out_addr     = out_valid ? addr : '0;
  assign w_plus_frac  = out_valid ? {carry[1], rd_plus[UNROLLING-1:1]}  : '0;
  assign w_minus_frac = out_valid ? {carry[0], rd_minus[UNROLLING-1:1]} : '0;
  assign lsb_pair     = {rd_plus[0], rd_minus[0]};
  assign accept       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!syn_reset_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      carry     <= '0;
      shift_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr  <= last_addr;
            carry <= shift_in;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_EMIT;
        ST_EMIT: begin
          if (accept) begin
            carry <= lsb_pair;
            if (addr == '0) begin
              shift_out <= lsb_pair;
              state     <= ST_FIN;
            end else begin
              addr  <= addr - 1'b1;
              state <= ST_FETCH;
            end
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef V_SHR_ZERO_FLAG_EN
  logic all_zero;

  always_ff @(posedge clk) begin
    if (!syn_reset_n) begin
      all_zero  <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        all_zero  <= 1'b1;
        zero_flag <= 1'b0;
      end else if (accept) begin
        all_zero <= all_zero && (w_plus_frac == '0) && (w_minus_frac == '0) &&
                    ((addr != '0) || (lsb_pair == '0));
      end else if (state == ST_FIN) begin
        zero_flag <= all_zero;
      end
    end
  end
`endif

endmodule

// File: tb/tb_v_frac_bits_shr_reader.sv
// Directed, table-driven bench for v_frac_bits_shr_reader at UNROLLING=8, ADDR_WIDTH=2.
module tb_v_frac_bits_shr_reader;

  localparam int AW = 2;
  localparam int UW = 8;

  logic          clk;
  logic          syn_reset_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [UW-1:0] wr_plus_frac;
  logic [UW-1:0] wr_minus_frac;
  logic          start;
  logic [AW-1:0] last_addr;
  logic [1:0]    shift_in;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [UW-1:0] w_plus_frac;
  logic [UW-1:0] w_minus_frac;
  logic [1:0]    shift_out;
  logic          done;
`ifdef V_SHR_ZERO_FLAG_EN
  logic          zero_flag;
`endif

  v_frac_bits_shr_reader #(
    .ADDR_WIDTH (AW),
    .UNROLLING  (UW)
  ) dut (
    .clk           (clk),
    .syn_reset_n   (syn_reset_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_plus_frac  (wr_plus_frac),
    .wr_minus_frac (wr_minus_frac),
    .start         (start),
    .last_addr     (last_addr),
    .shift_in      (shift_in),
    .busy          (busy),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_addr      (out_addr),
    .w_plus_frac   (w_plus_frac),
    .w_minus_frac  (w_minus_frac),
    .shift_out     (shift_out),
`ifdef V_SHR_ZERO_FLAG_EN
    .zero_flag     (zero_flag),
`endif
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] lp;
    logic [3:0][7:0] lm;
    logic [3:0][7:0] ep;
    logic [3:0][7:0] em;
    int              last;
    logic [1:0]      sin;
    logic [1:0]      eso;
    int              stall;
  } vec_t;

  vec_t vecs[7];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic set_vec(input int i, input logic [31:0] lp, input logic [31:0] lm, input int last,
                         input logic [1:0] sin, input logic [31:0] ep, input logic [31:0] em,
                         input logic [1:0] eso, input int stall);
    vecs[i].lp = lp;  vecs[i].lm = lm;
    vecs[i].ep = ep;  vecs[i].em = em;
    vecs[i].last = last; vecs[i].sin = sin;
    vecs[i].eso = eso;   vecs[i].stall = stall;
  endtask

  task automatic load_word(input int a, input logic [7:0] p, input logic [7:0] m);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(a); wr_plus_frac = p; wr_minus_frac = m;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_vec(input int vi);
    for (int a = 0; a < 4; a++) load_word(a, vecs[vi].lp[a], vecs[vi].lm[a]);
  endtask

  // Returns at the negedge of the first FETCH cycle.
  task automatic start_stream(input int vi);
    @(negedge clk);
    start = 1'b1; last_addr = AW'(vecs[vi].last); shift_in = vecs[vi].sin;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d busy_after_start", vi), busy, 1);
  endtask

  task automatic collect(input int vi, input int first_gap);
    int  n;
    logic zf;
    zf = (vecs[vi].eso == 2'b00);
    for (int a = vecs[vi].last; a >= 0; a--) begin
      n = 0;
      while (!out_valid && n < 8) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("v%0d a%0d valid", vi, a), out_valid, 1);
      if (!out_valid) return;
      if (a == vecs[vi].last) chk($sformatf("v%0d latency", vi), n, first_gap);
      chk($sformatf("v%0d a%0d addr", vi, a), out_addr, a);
      chk($sformatf("v%0d a%0d plus", vi, a), w_plus_frac, vecs[vi].ep[a]);
      chk($sformatf("v%0d a%0d minus", vi, a), w_minus_frac, vecs[vi].em[a]);
      if (vecs[vi].ep[a] != 8'h00 || vecs[vi].em[a] != 8'h00) zf = 1'b0;
      if (a == vecs[vi].stall) begin
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk($sformatf("v%0d stall%0d valid", vi, k), out_valid, 1);
          chk($sformatf("v%0d stall%0d addr", vi, k), out_addr, a);
          chk($sformatf("v%0d stall%0d plus", vi, k), w_plus_frac, vecs[vi].ep[a]);
          chk($sformatf("v%0d stall%0d minus", vi, k), w_minus_frac, vecs[vi].em[a]);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      chk($sformatf("v%0d a%0d valid_drop", vi, a), out_valid, 0);
    end
    chk($sformatf("v%0d done", vi), done, 1);
    chk($sformatf("v%0d shift_out", vi), shift_out, vecs[vi].eso);
    chk($sformatf("v%0d busy_fin", vi), busy, 0);
`ifdef V_SHR_ZERO_FLAG_EN
    @(negedge clk);
    chk($sformatf("v%0d zero_flag", vi), zero_flag, zf);
`else
    @(negedge clk);
`endif
    chk($sformatf("v%0d done_pulse", vi), done, 0);
    chk($sformatf("v%0d shift_out_hold", vi), shift_out, vecs[vi].eso);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    syn_reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_plus_frac = '0; wr_minus_frac = '0;
    start = 1'b0; last_addr = '0; shift_in = '0; out_ready = 1'b1;

    //      idx lp            lm            last sin    ep            em            eso    stall
    set_vec(0, 32'h00000301, 32'h00000000, 1, 2'b10, 32'h00008180, 32'h00000000, 2'b10, -1);
    set_vec(1, 32'h000000FF, 32'h00000001, 0, 2'b00, 32'h0000007F, 32'h00000000, 2'b11, -1);
    set_vec(2, 32'hA55A0080, 32'h3CC3FF01, 3, 2'b01, 32'h52AD0040, 32'h9E61FF80, 2'b01, 2);
    set_vec(3, 32'hFF01FE00, 32'hFF017F00, 2, 2'b11, 32'h0080FF00, 32'h0080BF80, 2'b00, -1);
    set_vec(4, 32'h00000000, 32'h00000000, 3, 2'b00, 32'h00000000, 32'h00000000, 2'b00, -1);
    set_vec(5, 32'h00000200, 32'h00000000, 1, 2'b00, 32'h00000100, 32'h00000000, 2'b00, -1);
    set_vec(6, 32'h00000010, 32'h00000020, 0, 2'b01, 32'h00000008, 32'h00000090, 2'b00, -1);

    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst valid", out_valid, 0);
    chk("rst done", done, 0);
    chk("rst addr", out_addr, 0);
    chk("rst plus", w_plus_frac, 0);
    chk("rst minus", w_minus_frac, 0);
    chk("rst shift_out", shift_out, 0);
`ifdef V_SHR_ZERO_FLAG_EN
    chk("rst zero_flag", zero_flag, 0);
`endif
    syn_reset_n = 1'b1;

    for (int vi = 0; vi < 6; vi++) begin
      load_vec(vi);
      start_stream(vi);
      collect(vi, 1);
    end

    // start and write while busy must both be dropped
    load_vec(2);
    start_stream(2);
    start = 1'b1; last_addr = '0; shift_in = 2'b11;
    wr_en = 1'b1; wr_addr = '0; wr_plus_frac = 8'hFF; wr_minus_frac = 8'hFF;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    collect(2, 0);

    // reset in EMIT abandons the stream; memory survives for a replay
    load_vec(0);
    start_stream(0);
    @(negedge clk);
    chk("mid valid_before", out_valid, 1);
    syn_reset_n = 1'b0;
    @(negedge clk);
    syn_reset_n = 1'b1;
    chk("mid busy", busy, 0);
    chk("mid valid", out_valid, 0);
    chk("mid done", done, 0);
    chk("mid addr", out_addr, 0);
    chk("mid plus", w_plus_frac, 0);
    chk("mid minus", w_minus_frac, 0);
    chk("mid shift_out", shift_out, 0);
    @(negedge clk);
    chk("mid no_done", done, 0);
    start_stream(0);
    collect(0, 1);

    // write and start in the same cycle: fetch sees the new word
    @(negedge clk);
    wr_en = 1'b1; wr_addr = '0; wr_plus_frac = 8'h10; wr_minus_frac = 8'h20;
    start = 1'b1; last_addr = '0; shift_in = 2'b01;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    chk("same busy", busy, 1);
    collect(6, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
